// File: rtl/tag_allocator_6_if.sv
// Request/release/query bundle between tag consumers and the tag allocator.
// The allocator side uses the slave modport; consumers use master.
interface tag_allocator_6_if;
    localparam int unsigned TAG_W = 6;

    logic             alloc_req;
    logic             alloc_gnt;
    logic [TAG_W-1:0] alloc_tag;
    logic             free_valid;
    logic [TAG_W-1:0] free_tag;
    logic             free_err;
    logic             flush;
    logic [TAG_W-1:0] query_tag;
    logic             query_live;
    logic [TAG_W:0]   count;
    logic             full;
    logic             empty;

    modport master (
        output alloc_req, free_valid, free_tag, flush, query_tag,
        input  alloc_gnt, alloc_tag, free_err, query_live, count, full, empty
    );

    modport slave (
        input  alloc_req, free_valid, free_tag, flush, query_tag,
        output alloc_gnt, alloc_tag, free_err, query_live, count, full, empty
    );
endinterface

// File: rtl/tag_allocator_6.sv
// Issues unique 6-bit tags from a live bitmap, reclaims them on release and
// answers a registered "is tag live" query using per-index equality compares.
module tag_allocator_6 #(
    parameter int unsigned NUM_TAGS = 16
) (
    input  logic             clk,
    input  logic             rst,
    tag_allocator_6_if.slave bus
);
    localparam int unsigned TAG_W = 6;
    localparam int unsigned CNT_W = TAG_W + 1;

    logic [NUM_TAGS-1:0] live_q,  live_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q,  full_d;
    logic                empty_q, empty_d;
    logic                gnt_q,   gnt_d;
    logic [TAG_W-1:0]    tag_q,   tag_d;
    logic                err_q,   err_d;
    logic                qlive_q, qlive_d;

    logic                any_free;
    logic [TAG_W-1:0]    pick;
    logic                free_hit;
    logic                query_hit;
    logic                do_grant;
    logic                do_release;

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        any_free = 1'b0;
        pick     = '0;
        for (int unsigned i = NUM_TAGS; i > 0; i--) begin
            if (!live_q[i-1]) begin
                any_free = 1'b1;
                pick     = TAG_W'(i - 1);
            end
        end
    end

    // Out-of-range tags match no index, so they never hit.
    always_comb begin
        free_hit  = 1'b0;
        query_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            free_hit  = free_hit  | (live_q[i] & (&(bus.free_tag  ~^ TAG_W'(i))));
            query_hit = query_hit | (live_q[i] & (&(bus.query_tag ~^ TAG_W'(i))));
        end
    end

    always_comb begin
        do_grant   = bus.alloc_req  & any_free & ~bus.flush;
        do_release = bus.free_valid & free_hit & ~bus.flush;

        live_d = live_q;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (do_release && (bus.free_tag == TAG_W'(i))) begin
                live_d[i] = 1'b0;
            end
            if (do_grant && (pick == TAG_W'(i))) begin
                live_d[i] = 1'b1;
            end
        end
        if (bus.flush) begin
            live_d = '0;
        end

        if (bus.flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(do_grant) - CNT_W'(do_release);
        end
        full_d  = (count_d == CNT_W'(NUM_TAGS));
        empty_d = (count_d == '0);

        gnt_d   = do_grant;
        tag_d   = do_grant ? pick : tag_q;
        err_d   = bus.free_valid & ~free_hit & ~bus.flush;
        qlive_d = query_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            gnt_q   <= 1'b0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            qlive_q <= 1'b0;
        end else begin
            live_q  <= live_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            gnt_q   <= gnt_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
            qlive_q <= qlive_d;
        end
    end

    assign bus.alloc_gnt  = gnt_q;
    assign bus.alloc_tag  = tag_q;
    assign bus.free_err   = err_q;
    assign bus.query_live = qlive_q;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
endmodule

// File: tb/tb_tag_allocator_6.sv
// Bench for tag_allocator_6: directed vector table, hand sequences for
// asynchronous reset, and a randomized run against a bitmap model.
module tb_tag_allocator_6;
    localparam int unsigned NT = 16;

    typedef struct {
        logic       req;
        logic       fv;
        logic [5:0] ftag;
        logic       fl;
        logic [5:0] qtag;
    } stim_t;

    typedef struct {
        logic       gnt;
        logic [5:0] tag;
        logic       err;
        logic       ql;
        logic [6:0] cnt;
        logic       full;
        logic       empty;
    } exp_t;

    typedef struct {
        string nm;
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tag_allocator_6_if bus ();

    tag_allocator_6 #(.NUM_TAGS(NT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    passed = 0;
    int    total  = 0;
    vec_t  tbl[$];
    exp_t  exp_q[$];
    string nm_q[$];

    logic       m_live[NT];
    logic [5:0] m_tag;

    task automatic chk(input string nm, input int unsigned act, input int unsigned req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, req);
    endtask

    task automatic compare(input string nm, input exp_t e);
        chk({nm, ".alloc_gnt"},  bus.alloc_gnt,  e.gnt);
        chk({nm, ".alloc_tag"},  bus.alloc_tag,  e.tag);
        chk({nm, ".free_err"},   bus.free_err,   e.err);
        chk({nm, ".query_live"}, bus.query_live, e.ql);
        chk({nm, ".count"},      bus.count,      e.cnt);
        chk({nm, ".full"},       bus.full,       e.full);
        chk({nm, ".empty"},      bus.empty,      e.empty);
    endtask

    function automatic stim_t S(logic req, logic fv, logic [5:0] ftag, logic fl, logic [5:0] qtag);
        stim_t s;
        s.req = req; s.fv = fv; s.ftag = ftag; s.fl = fl; s.qtag = qtag;
        return s;
    endfunction

    function automatic exp_t E(logic gnt, logic [5:0] tag, logic err, logic ql,
                               logic [6:0] cnt, logic full, logic empty);
        exp_t e;
        e.gnt = gnt; e.tag = tag; e.err = err; e.ql = ql;
        e.cnt = cnt; e.full = full; e.empty = empty;
        return e;
    endfunction

    task automatic add(input string nm, input stim_t s, input exp_t e);
        vec_t v;
        v.nm = nm; v.s = s; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic set_inputs(input stim_t s);
        bus.alloc_req  = s.req;
        bus.free_valid = s.fv;
        bus.free_tag   = s.ftag;
        bus.flush      = s.fl;
        bus.query_tag  = s.qtag;
    endtask

    // Inputs change on the falling edge; the expectation is scored after the next rising edge.
    task automatic drive(input string nm, input stim_t s, input exp_t e);
        @(negedge clk);
        set_inputs(s);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    function automatic exp_t model_step(input stim_t s);
        exp_t e;
        bit   found;
        int   pk;
        int   fi;
        int   qi;
        bit   hit;
        int   c;
        found = 1'b0;
        pk    = 0;
        for (int i = 0; i < NT; i++) begin
            if (!found && !m_live[i]) begin
                found = 1'b1;
                pk    = i;
            end
        end
        fi  = int'(s.ftag);
        qi  = int'(s.qtag);
        hit = (fi < NT) ? m_live[fi] : 1'b0;
        e.gnt = s.req && !s.fl && found;
        e.err = s.fv && !s.fl && !hit;
        e.ql  = (qi < NT) ? m_live[qi] : 1'b0;
        if (s.fl) begin
            for (int i = 0; i < NT; i++) m_live[i] = 1'b0;
        end else begin
            if (s.fv && hit) m_live[fi] = 1'b0;
            if (e.gnt) m_live[pk] = 1'b1;
        end
        if (e.gnt) m_tag = 6'(pk);
        e.tag = m_tag;
        c = 0;
        for (int i = 0; i < NT; i++) c += int'(m_live[i]);
        e.cnt   = 7'(c);
        e.full  = (c == NT);
        e.empty = (c == 0);
        return e;
    endfunction

    // Scoreboard consumer: one pending expectation per rising edge.
    initial begin
        exp_t  me;
        string mn;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                me = exp_q.pop_front();
                mn = nm_q.pop_front();
                compare(mn, me);
            end
        end
    end

    initial begin
        stim_t idle;
        stim_t rs;
        exp_t  re;
        idle = S(0, 0, 0, 0, 63);

        for (int i = 0; i < 16; i++)
            add("fill", S(1, 0, 0, 0, 0), E(1, 6'(i), 0, i > 0, 7'(i + 1), i == 15, 0));
        add("full_hold",    S(1, 0, 0,  0, 63), E(0, 15, 0, 0, 16, 1, 0));
        add("full_swap",    S(1, 1, 5,  0, 63), E(0, 15, 0, 0, 15, 0, 0));
        add("refill5",      S(1, 0, 0,  0, 63), E(1, 5,  0, 0, 16, 1, 0));
        add("flush_full",   S(1, 1, 9,  1, 63), E(0, 5,  0, 0, 0,  0, 1));
        add("after_flush",  S(1, 0, 0,  0, 63), E(1, 0,  0, 0, 1,  0, 0));
        add("err_notlive",  S(0, 1, 3,  0, 63), E(0, 0,  1, 0, 1,  0, 0));
        add("err_range20",  S(0, 1, 20, 0, 63), E(0, 0,  1, 0, 1,  0, 0));
        add("free0",        S(0, 1, 0,  0, 63), E(0, 0,  0, 0, 0,  0, 1));
        add("err_empty3",   S(0, 1, 3,  0, 63), E(0, 0,  1, 0, 0,  0, 1));
        add("err_drop",     idle,               E(0, 0,  0, 0, 0,  0, 1));
        for (int i = 0; i < 3; i++)
            add("alloc3", S(1, 0, 0, 0, 63), E(1, 6'(i), 0, 0, 7'(i + 1), 0, 0));
        add("q1",           S(0, 0, 0, 0, 1),   E(0, 2, 0, 1, 3, 0, 0));
        add("q1_free1",     S(0, 1, 1, 0, 1),   E(0, 2, 0, 1, 2, 0, 0));
        add("q1_after",     S(0, 0, 0, 0, 1),   E(0, 2, 0, 0, 2, 0, 0));
        add("q40",          S(0, 0, 0, 0, 40),  E(0, 2, 0, 0, 2, 0, 0));
        add("q2",           S(0, 0, 0, 0, 2),   E(0, 2, 0, 1, 2, 0, 0));
        add("swap_free2",   S(1, 1, 2, 0, 2),   E(1, 1, 0, 1, 2, 0, 0));
        add("q2_gone",      S(0, 0, 0, 0, 2),   E(0, 1, 0, 0, 2, 0, 0));
        add("flush_only",   S(0, 0, 0, 1, 63),  E(0, 1, 0, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++)
            add("alloc4", S(1, 0, 0, 0, 63), E(1, 6'(i), 0, 0, 7'(i + 1), 0, 0));
        add("flush_req",    S(1, 1, 9, 1, 0),   E(0, 3, 0, 1, 0, 0, 1));
        add("flush_next",   S(1, 0, 0, 0, 63),  E(1, 0, 0, 0, 1, 0, 0));

        rst = 1'b1;
        set_inputs(idle);
        #12;
        compare("reset", E(0, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) drive(tbl[i].nm, tbl[i].s, tbl[i].e);

        drive("pre_rst_a", S(1, 0, 0, 0, 63), E(1, 1, 0, 0, 2, 0, 0));
        drive("pre_rst_b", S(1, 0, 0, 0, 1),  E(1, 2, 0, 1, 3, 0, 0));
        @(posedge clk);
        #2;
        rst = 1'b1;
        set_inputs(idle);
        #1;
        compare("async_rst", E(0, 0, 0, 0, 0, 0, 1));
        #1;
        rst = 1'b0;
        drive("post_rst_idle", idle,               E(0, 0, 0, 0, 0, 0, 1));
        drive("post_rst_a0",   S(1, 0, 0, 0, 63),  E(1, 0, 0, 0, 1, 0, 0));
        drive("post_rst_a1",   S(1, 0, 0, 0, 0),   E(1, 1, 0, 1, 2, 0, 0));

        @(posedge clk);
        #2;
        rst = 1'b1;
        set_inputs(idle);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NT; i++) m_live[i] = 1'b0;
        m_tag = '0;
        for (int n = 0; n < 300; n++) begin
            rs.req  = $urandom_range(0, 9) < 7;
            rs.fv   = $urandom_range(0, 9) < 4;
            rs.ftag = 6'($urandom_range(0, 19));
            rs.fl   = $urandom_range(0, 39) == 0;
            rs.qtag = 6'($urandom_range(0, 19));
            re = model_step(rs);
            drive("rand", rs, re);
        end

        @(negedge clk);
        set_inputs(idle);
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
